fifo_sync_param: RTL

Parametrised synchronous FIFO with an integrated registered state machine. It replaces the fixed depth-8 next-state/count arrangement with one block that holds storage, pointers, count, status flags and per-cycle handshake responses. It generalises width and depth, and adds simultaneous read+write (RDWR) and almost-full/almost-empty flags. It sits between producer and consumer logic in the same clock domain.

---
 rtl/fifo_sync_param_if.sv | 48 ++++
 rtl/fifo_sync_param.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param_if.sv
// Handshake/data bundle between a producer/consumer (master) and
// fifo_sync_param (slave). When FIFO_ERR_CNT_EN is defined the bundle also
// carries the saturating error counters.
interface fifo_sync_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
);
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic [ADDR_WIDTH:0]   data_count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  wr_ack;
    logic                  wr_err;
    logic                  rd_ack;
    logic                  rd_err;
    logic [2:0]            state;
`ifdef FIFO_ERR_CNT_EN
    logic [7:0]            wr_err_cnt;
    logic [7:0]            rd_err_cnt;

    modport master (
        output wr_en, rd_en, din,
        input  dout, data_count, full, empty, almost_full, almost_empty,
               wr_ack, wr_err, rd_ack, rd_err, state, wr_err_cnt, rd_err_cnt
    );
    modport slave (
        input  wr_en, rd_en, din,
        output dout, data_count, full, empty, almost_full, almost_empty,
               wr_ack, wr_err, rd_ack, rd_err, state, wr_err_cnt, rd_err_cnt
    );
`else
    modport master (
        output wr_en, rd_en, din,
        input  dout, data_count, full, empty, almost_full, almost_empty,
               wr_ack, wr_err, rd_ack, rd_err, state
    );
    modport slave (
        input  wr_en, rd_en, din,
        output dout, data_count, full, empty, almost_full, almost_empty,
               wr_ack, wr_err, rd_ack, rd_err, state
    );
`endif
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with a registered request-decoding state
// machine. Each edge the write/read requests are resolved against the
// current occupancy; the outcome is recorded in `state` and in one-cycle
// ack/err flags. Simultaneous read+write in the middle range is a RDWR.
// Optional macro FIFO_ERR_CNT_EN adds 8-bit saturating error counters.
module fifo_sync_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_MARGIN  = 1,
    parameter int AE_MARGIN  = 1
) (
    input  logic               clk,
    input  logic               reset,
    fifo_sync_param_if.slave   bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C    = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_LEVEL_C = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);
    localparam logic [ADDR_WIDTH:0] AE_LEVEL_C = (ADDR_WIDTH+1)'(AE_MARGIN);

    typedef enum logic [2:0] {
        ST_INIT     = 3'b000,
        ST_READ     = 3'b001,
        ST_WRITE    = 3'b010,
        ST_RD_ERROR = 3'b011,
        ST_WR_ERROR = 3'b100,
        ST_NO_OP    = 3'b101,
        ST_RDWR     = 3'b110
    } state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] head_q, head_d;
    logic [ADDR_WIDTH-1:0] tail_q, tail_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  wr_err_q, wr_err_d;
    logic                  rd_ack_q, rd_ack_d;
    logic                  rd_err_q, rd_err_d;

    logic is_full;
    logic is_empty;
    logic state_legal;
    logic do_wr;
    logic do_rd;

    assign is_full     = (count_q == DEPTH_C);
    assign is_empty    = (count_q == '0);
    assign state_legal = (state_q != state_e'(3'b111));

    // Resolve this cycle's requests into the next state, actions and flags.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and no latch is inferred.
        state_d  = ST_NO_OP;
        do_wr    = 1'b0;
        do_rd    = 1'b0;
        wr_ack_d = 1'b0;
        wr_err_d = 1'b0;
        rd_ack_d = 1'b0;
        rd_err_d = 1'b0;

        if (state_legal) begin
            unique case ({bus.wr_en, bus.rd_en})
                2'b10: begin
                    if (is_full) begin
                        state_d  = ST_WR_ERROR;
                        wr_err_d = 1'b1;
                    end else begin
                        state_d  = ST_WRITE;
                        do_wr    = 1'b1;
                        wr_ack_d = 1'b1;
                    end
                end
                2'b01: begin
                    if (is_empty) begin
                        state_d  = ST_RD_ERROR;
                        rd_err_d = 1'b1;
                    end else begin
                        state_d  = ST_READ;
                        do_rd    = 1'b1;
                        rd_ack_d = 1'b1;
                    end
                end
                2'b11: begin
                    if (is_empty) begin
                        // Write lands but the read is refused; no bypass to dout.
                        state_d  = ST_WRITE;
                        do_wr    = 1'b1;
                        wr_ack_d = 1'b1;
                        rd_err_d = 1'b1;
                    end else if (is_full) begin
                        state_d  = ST_READ;
                        do_rd    = 1'b1;
                        rd_ack_d = 1'b1;
                        wr_err_d = 1'b1;
                    end else begin
                        state_d  = ST_RDWR;
                        do_wr    = 1'b1;
                        do_rd    = 1'b1;
                        wr_ack_d = 1'b1;
                        rd_ack_d = 1'b1;
                    end
                end
                default: state_d = ST_NO_OP;
            endcase
        end
    end

    // Pointer, occupancy and read-data next values from the decoded actions.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        dout_d  = dout_q;
        if (do_wr) begin
            tail_d = tail_q + ADDR_WIDTH'(1);
        end
        if (do_rd) begin
            head_d = head_q + ADDR_WIDTH'(1);
            dout_d = mem[head_q];
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + (ADDR_WIDTH+1)'(1);
        end else if (do_rd && !do_wr) begin
            count_d = count_q - (ADDR_WIDTH+1)'(1);
        end
    end

    // Control and status registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments keep every flop sampling the
        // pre-edge values regardless of statement order.
        if (reset) begin
            state_q  <= ST_INIT;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            wr_ack_q <= wr_ack_d;
            wr_err_q <= wr_err_d;
            rd_ack_q <= rd_ack_d;
            rd_err_q <= rd_err_d;
        end
    end

    // Storage array written at the tail on accepted writes.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; stale words are unreachable because
        // the pointers and count are reset.
        if (do_wr) begin
            mem[tail_q] <= bus.din;
        end
    end

`ifdef FIFO_ERR_CNT_EN
    logic [7:0] wr_err_cnt_q, wr_err_cnt_d;
    logic [7:0] rd_err_cnt_q, rd_err_cnt_d;
    logic       err_cnt_clr;

    assign err_cnt_clr = bus.wr_en && bus.rd_en && !is_empty && !is_full;

    // Saturating error counters, cleared by reset or an in-range dual request.
    always_comb begin
        wr_err_cnt_d = wr_err_cnt_q;
        rd_err_cnt_d = rd_err_cnt_q;
        if (err_cnt_clr) begin
            wr_err_cnt_d = '0;
            rd_err_cnt_d = '0;
        end else begin
            if (wr_err_d && wr_err_cnt_q != 8'hFF) begin
                wr_err_cnt_d = wr_err_cnt_q + 8'd1;
            end
            if (rd_err_d && rd_err_cnt_q != 8'hFF) begin
                rd_err_cnt_d = rd_err_cnt_q + 8'd1;
            end
        end
    end

    // Error counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_err_cnt_q <= '0;
            rd_err_cnt_q <= '0;
        end else begin
            wr_err_cnt_q <= wr_err_cnt_d;
            rd_err_cnt_q <= rd_err_cnt_d;
        end
    end

    assign bus.wr_err_cnt = wr_err_cnt_q;
    assign bus.rd_err_cnt = rd_err_cnt_q;
`else
    // Error counters are not built in this configuration.
`endif

    assign bus.dout         = dout_q;
    assign bus.data_count   = count_q;
    assign bus.full         = is_full;
    assign bus.empty        = is_empty;
    assign bus.almost_full  = (count_q >= AF_LEVEL_C);
    assign bus.almost_empty = (count_q <= AE_LEVEL_C);
    assign bus.wr_ack       = wr_ack_q;
    assign bus.wr_err       = wr_err_q;
    assign bus.rd_ack       = rd_ack_q;
    assign bus.rd_err       = rd_err_q;
    assign bus.state        = state_q;

endmodule
